// File: rtl/bank_bitplane_scatter_pkg.sv
// bank_bitplane_scatter_pkg: shared sizing, FSM encoding and bank-slice helper.
package bank_bitplane_scatter_pkg;
  localparam int DEF_N_BANK = 16;
  localparam int DEF_IN_W   = 8;
  localparam int DEF_IDX_W  = $clog2(DEF_IN_W);
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/bank_bitplane_scatter_select.sv
// bitplane_select: gathers bit idx of every bank element into one plane.
module bitplane_select
  import bank_bitplane_scatter_pkg::*;
#(
  parameter int N_BANK = DEF_N_BANK,
  parameter int IN_W   = DEF_IN_W,
  parameter int IDX_W  = $clog2(IN_W)
) (
  input  logic [N_BANK*IN_W-1:0] vec,
  input  logic [IDX_W-1:0]       idx,
  output logic [N_BANK-1:0]      plane
);
  for (genvar k = 0; k < N_BANK; k++) begin : g_bank
    logic [IN_W-1:0] elem;
    assign elem     = vec[slice_lo(k, IN_W) +: IN_W];
    assign plane[k] = elem[idx];
  end
endmodule

// File: rtl/bank_bitplane_scatter.sv
// bank_bitplane_scatter: streams each activation vector as LSB-first bit-planes
// with a one-deep pending slot so consecutive vectors run without a bubble.
module bank_bitplane_scatter
  import bank_bitplane_scatter_pkg::*;
#(
  parameter int N_BANK = DEF_N_BANK,
  parameter int IN_W   = DEF_IN_W,
  parameter int IDX_W  = $clog2(IN_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_BANK*IN_W-1:0] in_data,
  input  logic                   in_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_BANK-1:0]      out_plane,
  output logic [IDX_W-1:0]       out_bit_idx,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   out_neg,
  output logic                   busy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(IN_W - 1);
  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [N_BANK*IN_W-1:0]  act_data, act_data_n, pend_data, pend_data_n;
  logic                    act_signed, act_signed_n, pend_signed, pend_signed_n;
  logic                    pend_valid, pend_valid_n;
  logic [N_BANK-1:0]       plane;
  logic                    acc, fire;

  assign acc  = in_valid && in_ready;
  assign fire = out_valid && out_ready;

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    act_data_n    = act_data;
    act_signed_n  = act_signed;
    pend_valid_n  = pend_valid;
    pend_data_n   = pend_data;
    pend_signed_n = pend_signed;
    if (state == IDLE) begin
      if (acc) begin
        state_n      = STREAM;
        idx_n        = '0;
        act_data_n   = in_data;
        act_signed_n = in_signed;
      end
    end else if (fire && idx == LAST) begin
      idx_n        = '0;
      state_n      = (pend_valid || acc) ? STREAM : IDLE;
      act_data_n   = pend_valid ? pend_data : in_data;
      act_signed_n = pend_valid ? pend_signed : in_signed;
      pend_valid_n = 1'b0;
    end else begin
      idx_n = fire ? idx + IDX_W'(1) : idx;
      if (acc) begin
        pend_valid_n  = 1'b1;
        pend_data_n   = in_data;
        pend_signed_n = in_signed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      act_data    <= '0;
      act_signed  <= 1'b0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      pend_signed <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      act_data    <= act_data_n;
      act_signed  <= act_signed_n;
      pend_valid  <= pend_valid_n;
      pend_data   <= pend_data_n;
      pend_signed <= pend_signed_n;
    end
  end

  bitplane_select #(.N_BANK(N_BANK), .IN_W(IN_W), .IDX_W(IDX_W)) u_sel (
    .vec   (act_data),
    .idx   (idx),
    .plane (plane)
  );

  // Outputs are pure functions of registered state, so they hold while stalled.
  assign out_valid   = state == STREAM;
  assign out_plane   = out_valid ? plane : '0;
  assign out_bit_idx = idx;
  assign out_first   = out_valid && idx == '0;
  assign out_last    = out_valid && idx == LAST;
  assign out_neg     = out_last && act_signed;
  assign in_ready    = !pend_valid;
  assign busy        = out_valid || pend_valid;
endmodule

// File: tb/tb_bank_bitplane_scatter.sv
// tb_bank_bitplane_scatter: table vectors, directed corner sequences and a
// randomized run against a plane-queue reference model.
module tb_bank_bitplane_scatter;
  logic         clk = 0, rst_n = 0;
  logic         in_valid = 0, in_ready, in_signed = 0;
  logic [127:0] in_data = '0;
  logic         out_valid, out_ready = 1;
  logic [15:0]  out_plane;
  logic [2:0]   out_bit_idx;
  logic         out_first, out_last, out_neg, busy;
  int           total = 0, bad = 0;
  logic         sb_en = 0;
  logic [21:0]  q[$];
  logic [21:0]  prev;
  logic         prev_stall = 0;

  typedef struct {
    logic [127:0]      data;
    logic              sgn;
    logic [7:0][15:0]  planes;
  } vec_t;
  vec_t tbl[5];

  bank_bitplane_scatter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_plane(out_plane), .out_bit_idx(out_bit_idx),
    .out_first(out_first), .out_last(out_last), .out_neg(out_neg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] cur();
    return {out_plane, out_bit_idx, out_first, out_last, out_neg};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) step();
    chk("idle_wait", busy, 0);
  endtask

  task automatic send(input logic [127:0] d, input logic s);
    in_data = d; in_signed = s; in_valid = 1;
    step();
    in_valid = 0;
  endtask

  // Reference: plane b bank k is simply bit b of element k; flags from b and sign.
  always @(negedge clk) if (sb_en) begin
    if (prev_stall) chk("rnd_hold", {out_valid, cur()}, {1'b1, prev});
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("rnd_extra_plane", 1, 0);
      else chk("rnd_plane", cur(), q.pop_front());
    end
    prev_stall = out_valid && !out_ready;
    prev = cur();
    if (in_valid && in_ready)
      for (int b = 0; b < 8; b++) begin
        logic [15:0] p;
        for (int k = 0; k < 16; k++) p[k] = in_data[k*8 + b];
        q.push_back({p, 3'(b), b == 0, b == 7, in_signed && b == 7});
      end
  end

  initial begin
    logic [127:0] v3[3];
    logic [15:0]  got[24];
    logic [21:0]  snap;
    int           n, v;
    logic         gap, saw_nr, acc;
    for (int k = 0; k < 16; k++) tbl[0].data[k*8 +: 8] = 8'(k);
    tbl[0].sgn = 0;
    tbl[0].planes = {16'h0, 16'h0, 16'h0, 16'h0, 16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};
    tbl[1].data = {16{8'h80}}; tbl[1].sgn = 1;
    tbl[1].planes = {16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbl[2].data = {16{8'hFF}}; tbl[2].sgn = 0; tbl[2].planes = {8{16'hFFFF}};
    tbl[3].data = '0;          tbl[3].sgn = 0; tbl[3].planes = '0;
    tbl[4].data = {16{8'h55}}; tbl[4].sgn = 1; tbl[4].planes = {4{16'h0000, 16'hFFFF}};

    step();
    chk("rst_out", {out_valid, cur()}, 0);
    chk("rst_ready_busy", {in_ready, busy}, 2'b10);
    rst_n = 1;
    step();

    for (int i = 0; i < 5; i++) begin
      wait_idle();
      send(tbl[i].data, tbl[i].sgn);
      for (int b = 0; b < 8; b++) begin
        chk($sformatf("tbl%0d_p%0d", i, b), {out_valid, cur()},
            {1'b1, tbl[i].planes[b], 3'(b), b == 0, b == 7, tbl[i].sgn && b == 7});
        step();
      end
      chk($sformatf("tbl%0d_done", i), out_valid, 0);
    end

    // back-to-back: three vectors offered continuously
    wait_idle();
    v3[0] = {16{8'hFF}}; v3[1] = '0; v3[2] = {16{8'h55}};
    v = 0; n = 0; gap = 0; saw_nr = 0;
    in_data = v3[0]; in_signed = 0; in_valid = 1;
    for (int c = 0; c < 32; c++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        v++;
        if (v < 3) in_data = v3[v]; else in_valid = 0;
      end
      if (!in_ready) saw_nr = 1;
      if (out_valid && n < 24) begin got[n] = out_plane; n++; end
      else if (n > 0 && n < 24) gap = 1;
    end
    chk("b2b_count", n, 24);
    chk("b2b_gap", gap, 0);
    chk("b2b_ready_drop", saw_nr, 1);
    for (int i = 0; i < 24; i++)
      chk($sformatf("b2b_p%0d", i), got[i],
          i < 8 ? 16'hFFFF : i < 16 ? 16'h0000 : (i % 2 == 0 ? 16'hFFFF : 16'h0000));

    // backpressure at idx 3
    wait_idle();
    send(tbl[0].data, 0);
    repeat (3) step();
    snap = cur();
    chk("bp_at3", {out_valid, snap}, {1'b1, 16'hFF00, 3'd3, 3'b000});
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), {out_valid, cur()}, {1'b1, snap});
    end
    out_ready = 1;
    step();
    chk("bp_resume4", {out_valid, cur()}, {1'b1, 16'h0000, 3'd4, 3'b000});

    // reset mid-stream at idx 4 with pending full
    wait_idle();
    in_data = tbl[0].data; in_signed = 0; in_valid = 1;
    step();
    in_data = tbl[2].data;
    step();
    in_valid = 0;
    for (int i = 0; i < 10 && out_bit_idx != 3'd4; i++) step();
    chk("rst_mid_state", {out_valid, out_bit_idx, in_ready}, {1'b1, 3'd4, 1'b0});
    #2 rst_n = 0;
    #1;
    chk("rst_mid_out", {out_valid, busy, in_ready, out_plane}, {3'b001, 16'h0});
    step();
    rst_n = 1;
    step();
    chk("rst_after_idle", {out_valid, busy}, 0);
    send(tbl[2].data, 0);
    chk("rst_new_p0", {out_valid, cur()}, {1'b1, 16'hFFFF, 3'd0, 3'b100});

    // same-cycle direct load on last-plane fire
    wait_idle();
    send(tbl[3].data, 0);
    repeat (7) step();
    chk("dl_at7", {out_valid, out_bit_idx, in_ready}, {1'b1, 3'd7, 1'b1});
    in_data = {16{8'h01}}; in_signed = 0; in_valid = 1;
    step();
    in_valid = 0;
    chk("dl_p0", {out_valid, cur()}, {1'b1, 16'hFFFF, 3'd0, 3'b100});
    step();
    chk("dl_p1", {out_valid, cur()}, {1'b1, 16'h0000, 3'd1, 3'b000});

    // randomized run against the reference queue
    wait_idle();
    q.delete();
    sb_en = 1;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_signed = $urandom % 2;
      out_ready = ($urandom % 4) != 0;
      step();
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 100 && (busy || q.size() != 0); i++) step();
    step();
    sb_en = 0;
    chk("rnd_drain_q", q.size(), 0);
    chk("rnd_drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bank_bitplane_scatter.md
Name: bank_bitplane_scatter

Overview:
- Input-side counterpart of the bank reduction path: takes one activation vector (16 banks x 8 bit) per handshake and streams it bit-serially as 16-bit bit-planes, one per cycle, LSB plane first, to drive the 16 CIM banks.
- Tags every plane with a bit index, first/last flags and a negative-weight flag, so the downstream shift-accumulator behind the adder tree can weight the per-cycle sums.
- Holds a one-deep pending buffer so consecutive vectors stream with no bubble.

Parameters:
- N_BANK, 16, number of banks, which is also the plane width.
- IN_W, 8, bits per bank element, which is also the number of planes per vector.
- IDX_W, 3, width of the bit index; must equal clog2(IN_W).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  vector offered
- in_ready  out  1  vector can be accepted
- in_data  in  N_BANK*IN_W  bank k element at bits [k*IN_W +: IN_W]
- in_signed  in  1  vector is two's complement; captured with in_data
- out_valid  out  1  plane valid
- out_ready  in  1  downstream accepts plane
- out_plane  out  N_BANK  bit out_bit_idx of each bank element; bank k on bit k
- out_bit_idx  out  IDX_W  plane index, 0..IN_W-1
- out_first  out  1  out_bit_idx==0
- out_last  out  1  out_bit_idx==IN_W-1
- out_neg  out  1  out_last && captured in_signed (MSB plane carries weight -2^(IN_W-1))
- busy  out  1  active or pending vector present

Behaviour:
- Reset (async, applies mid-stream too): all out_* = 0, busy = 0, in_ready = 1. Active and pending vectors are discarded; no partial plane sequence resumes.
- Storage: ACTIVE vector register (bit-index counter plus signed flag) and PENDING vector register (valid flag plus signed flag).
- in_ready = !pending_valid. It is driven from a register, never from out_ready.
- Input accept = in_valid && in_ready.
- Output fire = out_valid && out_ready.
- All out_* signals are registered. While out_valid && !out_ready, all out_* hold stable.
- FSM states:
  - IDLE: out_valid=0.
    - On accept: load ACTIVE, go to STREAM.
    - Plane 0 appears at out_* on the cycle after the accept (latency 1).
  - STREAM: out_valid=1, presenting plane idx of ACTIVE.
    - On fire with idx<IN_W-1: idx+1 on the next cycle.
    - On fire with idx==IN_W-1:
      - If PENDING valid: PENDING moves to ACTIVE, plane 0 presented on the next cycle (no bubble), PENDING cleared.
      - Else, if an input is accepted in the same cycle: that vector goes directly to ACTIVE, plane 0 on the next cycle.
      - Else: go to IDLE.
    - An accept during STREAM that does not take the direct-load path goes to PENDING.
- Simultaneous accept and last-plane fire with PENDING full cannot occur, because in_ready=0.
- Throughput: sustained 1 plane/cycle; IN_W cycles per vector when out_ready is held at 1.
- Plane contents: out_plane[k] = elem_k[out_bit_idx]. Planes are extracted by index; the stored vector is not modified. An all-zero vector still emits all IN_W planes.
- out_neg = 1 only on the last plane of a vector captured with in_signed=1.
- busy = (state==STREAM) || pending_valid.
- Backpressure of any length is lossless; the bit index never advances without a fire.

Decomposition:
- Shared package: N_BANK and IN_W defaults, IDX_W derivation, FSM state encoding (IDLE, STREAM), and the bank-slice helper (k*IN_W offset).
- One sub-module: bitplane_select. Combinational; from a vector and an index it produces the N_BANK-bit plane. It is instantiated once on ACTIVE.
- FSM, counter and PENDING register stay in the top module.

Test Plan:
- Single vector, out_ready=1:
  - Stimulus: bank k = k (0..15), unsigned.
  - Required response: 8 consecutive planes starting 1 cycle after accept, plane b = {bit b of 15..0}. Plane 0 = 0xAAAA, plane 1 = 0xCCCC, plane 2 = 0xF0F0, plane 3 = 0xFF00, planes 4..7 = 0x0000.
  - Flags: first on idx 0, last on idx 7, out_neg=0 throughout.
- Signed vector:
  - Stimulus: all banks = 0x80, in_signed=1.
  - Required response: planes 0..6 = 0x0000, plane 7 = 0xFFFF with out_last=1 and out_neg=1.
- Back-to-back:
  - Stimulus: three vectors offered continuously, first all 0xFF, then all 0x00, then all 0x55.
  - Required response: 24 planes in 24 consecutive cycles with no gap; 0xFFFF x8, then 0x0000 x8, then alternating 0xFFFF/0x0000 x8.
  - in_ready drops while PENDING is full.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles at idx 3.
  - Required response: out_* held stable, then stream resumes at idx 3 then 4. No plane lost or duplicated.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 at idx 4 with PENDING full.
  - Required response: out_valid=0, busy=0, in_ready=1 immediately. After release, a new vector starts at idx 0.
- Same-cycle direct load:
  - Stimulus: last-plane fire with PENDING empty and in_valid=1 in the same cycle.
  - Required response: the new vector's plane 0 appears on the next cycle with out_first=1.
